// File: rtl/bcast_fanout.sv
// Broadcast fan-out stage of the collective router. Each buffered result flit
// is replicated once per configured torus child, plus an optional host copy.
module bcast_fanout #(
  parameter logic [2:0] RANK_X        = 3'd0,
  parameter logic [2:0] RANK_Y        = 3'd0,
  parameter logic [2:0] RANK_Z        = 3'd0,
  parameter logic [5:0] CHILD_MASK    = 6'b000000,
  parameter logic       LOCAL_DELIVER = 1'b0,
  parameter int         FIFO_DEPTH    = 4,
  parameter int         FlitWidth     = 73
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [FlitWidth-1:0]            in_flit,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [FlitWidth-1:0]            out_flit,
  output logic [2:0]                      out_port,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [6:0]    PORT_MASK  = {LOCAL_DELIVER, CHILD_MASK};

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state;
  logic [FlitWidth-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [FlitWidth-1:0] head;
  logic [FlitWidth-1:0] work;
  logic [6:0]           rem;
  logic [6:0]           rem_next;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 xfer;

  // Lowest set bit of a port mask; ports are served in ascending order.
  function automatic logic [2:0] first_port(input logic [6:0] m);
    first_port = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (m[i]) first_port = 3'(i);
    end
  endfunction

  // Build the copy for one direction: dst is the neighbour (mod-8 wrap), or
  // this node for the host port; src is this node; the body is untouched.
  function automatic logic [FlitWidth-1:0] make_copy(input logic [FlitWidth-1:0] f,
                                                     input logic [2:0] p);
    logic [2:0] dx;
    logic [2:0] dy;
    logic [2:0] dz;
    dx = RANK_X;
    dy = RANK_Y;
    dz = RANK_Z;
    case (p)
      3'd0:    dx = RANK_X + 3'd1;
      3'd1:    dx = RANK_X - 3'd1;
      3'd2:    dy = RANK_Y + 3'd1;
      3'd3:    dy = RANK_Y - 3'd1;
      3'd4:    dz = RANK_Z + 3'd1;
      3'd5:    dz = RANK_Z - 3'd1;
      default: ;
    endcase
    make_copy = {1'b1, dz, dy, dx, RANK_Z, RANK_Y, RANK_X, f[53:0]};
  endfunction

  // Handshakes: a beat moves on a rising edge where valid and ready are both
  // high. in_ready depends only on occupancy; out_flit/out_port hold while
  // out_valid is high and out_ready is low.
  assign in_ready   = (fifo_count != FULL_COUNT);
  assign fifo_empty = (fifo_count == '0);
  assign push       = in_valid && in_ready && in_flit[72];
  assign xfer       = out_valid && out_ready;
  assign rem_next   = rem & ~(7'b1 << out_port);
  assign head       = mem[rd_ptr];
  assign busy       = (state == SEND);

  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (PORT_MASK == 7'd0) begin
        pop = 1'b1;
      end else if (state == IDLE) begin
        pop = 1'b1;
      end else if (xfer && rem_next == 7'd0) begin
        pop = 1'b1;
      end
    end
  end

  // Storage has no reset: contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      rem       <= '0;
      out_flit  <= '0;
      out_port  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // With an empty port mask pop still fires and the flit is dropped.
          if (pop && PORT_MASK != 7'd0) begin
            state     <= SEND;
            work      <= head;
            rem       <= PORT_MASK;
            out_port  <= first_port(PORT_MASK);
            out_flit  <= make_copy(head, first_port(PORT_MASK));
            out_valid <= 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            if (rem_next != 7'd0) begin
              rem      <= rem_next;
              out_port <= first_port(rem_next);
              out_flit <= make_copy(work, first_port(rem_next));
            end else if (pop) begin
              work     <= head;
              rem      <= PORT_MASK;
              out_port <= first_port(PORT_MASK);
              out_flit <= make_copy(head, first_port(PORT_MASK));
            end else begin
              state     <= IDLE;
              rem       <= '0;
              out_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
